// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture
//  Purpose  : Circular on-chip trace buffer for retired-instruction samples
//             (PC + write-back data). Capture stops on a PC-match trigger
//             after a programmable number of post-trigger samples, or on a
//             cycle-count timeout. Registered read port, oldest-first index.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_capture #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8,
    parameter int TIMEOUT  = 267
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_arm,
    input  logic                     i_vld,
    input  logic [DATA_W-1:0]        i_pc,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_trig_en,
    input  logic [DATA_W-1:0]        i_trig_pc,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_pc,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [1:0]               o_state,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_trig_hit,
    output logic [$clog2(DEPTH)-1:0] o_trig_idx,
    output logic                     o_done,
    output logic                     o_timeout
);

    localparam int c_aw = $clog2(DEPTH);
    // Cycle counter only has to hold 0..TIMEOUT-1
    localparam int c_cw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_aw-1:0] c_post     = c_aw'(POST_CNT);
    localparam logic [c_aw:0]   c_full     = (c_aw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_cyc_last = c_cw'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DATA_W-1:0]  r_mem_pc   [DEPTH];
    logic [DATA_W-1:0]  r_mem_data [DEPTH];

    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw:0]      r_count;
    logic [c_aw-1:0]    r_post_cnt;
    logic [c_cw-1:0]    r_cyc;
    logic [c_aw-1:0]    r_trig_ptr;
    logic               r_trig_hit;
    logic [c_aw-1:0]    r_trig_idx;
    logic               r_timeout;
    logic [DATA_W-1:0]  r_rd_pc;
    logic [DATA_W-1:0]  r_rd_data;

    logic               w_capturing;
    logic               w_start;
    logic               w_wr;
    logic               w_trig;
    logic               w_post_last;
    logic               w_tmo;
    logic [c_aw-1:0]    w_wr_ptr_nxt;
    logic [c_aw:0]      w_count_nxt;
    logic [c_aw-1:0]    w_trig_ptr_nxt;
    logic [c_aw-1:0]    w_oldest_nxt;
    logic [c_aw-1:0]    w_trig_idx_nxt;
    logic [c_aw-1:0]    w_rd_oldest;
    logic [c_aw-1:0]    w_rd_phys;

    assign w_capturing = (r_state == ST_PRE) || (r_state == ST_POST);
    assign w_start     = i_arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wr        = w_capturing && i_vld;
    assign w_trig      = (r_state == ST_PRE) && i_vld && i_trig_en && (i_pc == i_trig_pc);
    assign w_post_last = (r_state == ST_POST) && i_vld && (r_post_cnt == c_aw'(1));
    assign w_tmo       = w_capturing && (r_cyc == c_cyc_last);

    // Post-edge pointer/count view, used to resolve the trigger's logical
    // index on the very edge that freezes the buffer.
    assign w_wr_ptr_nxt   = w_wr ? (r_wr_ptr + 1'b1) : r_wr_ptr;
    assign w_count_nxt    = (w_wr && (r_count != c_full)) ? (r_count + 1'b1) : r_count;
    assign w_trig_ptr_nxt = w_trig ? r_wr_ptr : r_trig_ptr;
    assign w_oldest_nxt   = (w_count_nxt == c_full) ? w_wr_ptr_nxt : '0;
    assign w_trig_idx_nxt = w_trig_ptr_nxt - w_oldest_nxt;

    // Logical-to-physical read mapping: index 0 is the oldest surviving entry
    assign w_rd_oldest = (r_count == c_full) ? r_wr_ptr : '0;
    assign w_rd_phys   = w_rd_oldest + i_rd_addr;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: timeout outranks trigger completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_arm) begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (w_tmo) begin
                    w_state_nxt = ST_DONE;
                end else if (w_trig) begin
                    w_state_nxt = (POST_CNT == 0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (w_tmo || w_post_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture bookkeeping: pointers, counters and trigger/timeout status
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_cyc      <= '0;
            r_trig_ptr <= '0;
            r_trig_hit <= 1'b0;
            r_trig_idx <= '0;
            r_timeout  <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_cyc      <= '0;
            r_trig_hit <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (w_capturing) begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_trig_ptr <= w_trig_ptr_nxt;
            r_cyc      <= r_cyc + 1'b1;
            if (w_trig) begin
                r_trig_hit <= 1'b1;
                r_post_cnt <= c_post;
            end else if ((r_state == ST_POST) && i_vld) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
            if ((w_state_nxt == ST_DONE) && (w_trig || r_trig_hit)) begin
                r_trig_idx <= w_trig_idx_nxt;
            end
        end
    end

    // Sample storage; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem_pc[r_wr_ptr]   <= i_pc;
            r_mem_data[r_wr_ptr] <= i_data;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_pc   <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_pc   <= r_mem_pc[w_rd_phys];
            r_rd_data <= r_mem_data[w_rd_phys];
        end
    end

    assign o_rd_pc    = r_rd_pc;
    assign o_rd_data  = r_rd_data;
    assign o_state    = r_state;
    assign o_count    = r_count;
    assign o_trig_hit = r_trig_hit;
    assign o_trig_idx = r_trig_idx;
    assign o_done     = (r_state == ST_DONE);
    assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_capture
//  Purpose  : Self-checking bench for trace_capture. Two instances share one
//             stimulus stream (POST_CNT=3 and POST_CNT=0); a sample-history
//             reference model predicts state, count, flags and read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_capture;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 50;
    localparam int AW      = 3;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              arm     = 1'b0;
    logic              vld     = 1'b0;
    logic              trig_en = 1'b0;
    logic [DATA_W-1:0] pc      = '0;
    logic [DATA_W-1:0] data    = '0;
    logic [DATA_W-1:0] trig_pc = '0;
    logic [AW-1:0]     rd_addr = '0;

    logic [DATA_W-1:0] rpc  [2];
    logic [DATA_W-1:0] rdat [2];
    logic [1:0]        st   [2];
    logic [AW:0]       cnt  [2];
    logic              hit  [2];
    logic [AW-1:0]     tidx [2];
    logic              done [2];
    logic              tout [2];

    int n_checks = 0;
    int n_fail   = 0;

    trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_CNT(3), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_vld(vld), .i_pc(pc), .i_data(data),
        .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_addr(rd_addr),
        .o_rd_pc(rpc[0]), .o_rd_data(rdat[0]), .o_state(st[0]), .o_count(cnt[0]),
        .o_trig_hit(hit[0]), .o_trig_idx(tidx[0]), .o_done(done[0]), .o_timeout(tout[0])
    );

    trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_CNT(0), .TIMEOUT(TIMEOUT)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_vld(vld), .i_pc(pc), .i_data(data),
        .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_rd_addr(rd_addr),
        .o_rd_pc(rpc[1]), .o_rd_data(rdat[1]), .o_state(st[1]), .o_count(cnt[1]),
        .o_trig_hit(hit[1]), .o_trig_idx(tidx[1]), .o_done(done[1]), .o_timeout(tout[1])
    );

    always #5 clk = ~clk;

    // ---------------- reference model: full sample history per capture ----
    int          m_phase [2];   // 0 idle, 1 pre, 2 post, 3 done
    int          m_n     [2];   // samples recorded since arm
    int          m_cyc   [2];   // clocks spent capturing
    int          m_tpos  [2];   // history position of trigger sample, -1 none
    int          m_left  [2];
    bit          m_tout  [2];
    logic [63:0] m_hist  [2][128];

    function automatic int post_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic int m_cnt(input int d);
        return (m_n[d] < DEPTH) ? m_n[d] : DEPTH;
    endfunction

    function automatic logic [63:0] m_entry(input int d, input int i);
        return m_hist[d][m_n[d] - m_cnt(d) + i];
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_n[d] = 0; m_cyc[d] = 0;
            m_tpos[d]  = -1; m_left[d] = 0; m_tout[d] = 1'b0;
        end
    endtask

    task automatic m_step(input int d);
        int nxt;
        nxt = m_phase[d];
        if (m_phase[d] == 0 || m_phase[d] == 3) begin
            if (arm) begin
                nxt = 1; m_n[d] = 0; m_cyc[d] = 0; m_tpos[d] = -1; m_tout[d] = 1'b0;
            end
        end else begin
            if (vld) begin
                m_hist[d][m_n[d]] = {pc, data};
                m_n[d]++;
                if (m_phase[d] == 1 && trig_en && pc == trig_pc) begin
                    m_tpos[d] = m_n[d] - 1;
                    if (post_of(d) == 0) nxt = 3;
                    else begin nxt = 2; m_left[d] = post_of(d); end
                end else if (m_phase[d] == 2) begin
                    m_left[d]--;
                    if (m_left[d] == 0) nxt = 3;
                end
            end
            if (m_cyc[d] == TIMEOUT - 1) begin
                nxt = 3; m_tout[d] = 1'b1;
            end
            m_cyc[d]++;
        end
        m_phase[d] = nxt;
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input int d, input bit rd_ok, input logic [63:0] exp_rd);
        chk($sformatf("u%0d.state", d),    st[d],   m_phase[d]);
        chk($sformatf("u%0d.count", d),    cnt[d],  m_cnt(d));
        chk($sformatf("u%0d.done", d),     done[d], m_phase[d] == 3);
        chk($sformatf("u%0d.timeout", d),  tout[d], m_tout[d]);
        chk($sformatf("u%0d.trig_hit", d), hit[d],  m_tpos[d] >= 0);
        if (m_phase[d] == 3 && m_tpos[d] >= 0)
            chk($sformatf("u%0d.trig_idx", d), tidx[d], m_tpos[d] - (m_n[d] - m_cnt(d)));
        if (rd_ok) begin
            chk($sformatf("u%0d.rd_pc", d),   rpc[d],  exp_rd[63:32]);
            chk($sformatf("u%0d.rd_data", d), rdat[d], exp_rd[31:0]);
        end
    endtask

    // One clock: model follows the inputs held across the edge, DUT sampled 1ns later
    task automatic cycle();
        logic [63:0] exp_rd [2];
        bit          rd_ok  [2];
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            rd_ok[d]  = int'(rd_addr) < m_cnt(d);
            exp_rd[d] = rd_ok[d] ? m_entry(d, int'(rd_addr)) : '0;
            m_step(d);
        end
        #1;
        for (int d = 0; d < 2; d++) check_dut(d, rd_ok[d], exp_rd[d]);
    endtask

    // Called 1ns after an edge: reset lands mid-cycle, outputs checked before next edge
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        m_reset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst.u%0d.state", d),    st[d],   0);
            chk($sformatf("rst.u%0d.count", d),    cnt[d],  0);
            chk($sformatf("rst.u%0d.done", d),     done[d], 0);
            chk($sformatf("rst.u%0d.trig_hit", d), hit[d],  0);
            chk($sformatf("rst.u%0d.trig_idx", d), tidx[d], 0);
            chk($sformatf("rst.u%0d.timeout", d),  tout[d], 0);
            chk($sformatf("rst.u%0d.rd_pc", d),    rpc[d],  0);
            chk($sformatf("rst.u%0d.rd_data", d),  rdat[d], 0);
        end
        #2 rst = 1'b0;
    endtask

    // Arm, then feed pc=4k every cycle until both instances are done
    task automatic capture(input logic [DATA_W-1:0] tpc, input logic ten, output int k_end);
        trig_pc = tpc; trig_en = ten;
        arm = 1'b1; vld = 1'b0;
        cycle();
        arm = 1'b0; vld = 1'b1;
        k_end = -1;
        for (int k = 0; k < 60; k++) begin
            pc = DATA_W'(4 * k); data = $urandom;
            cycle();
            if (done[0] && done[1]) begin
                k_end = k;
                break;
            end
        end
        vld = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        vld = 1'b0; arm = 1'b0;
        while (!(done[0] && done[1]) && n < 60) begin
            cycle();
            n++;
        end
        chk("wait_done", done[0] && done[1], 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        async_reset();

        // Reset mid-capture while in POST
        trig_pc = 32'h8; trig_en = 1'b1; rd_addr = 3'd1;
        arm = 1'b1; cycle(); arm = 1'b0; vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = DATA_W'(4 * i); data = $urandom | 32'h1;
            cycle();
            if (st[0] == 2'd2) break;
        end
        chk("s1.in_post", st[0], 2);
        pc = 32'hC; data = $urandom; cycle();
        async_reset();
        vld = 1'b0; rd_addr = '0;
        cycle();

        // Trigger at 0x28 with 3 post samples
        capture(32'h28, 1'b1, k);
        chk("s2.k_done", k, 13);
        chk("s2.count", cnt[0], 8);
        chk("s2.trig_idx", tidx[0], 4);
        chk("s2.timeout", tout[0], 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i);
            cycle();
            chk($sformatf("s2.rd%0d", i), rpc[0], 32'h18 + 4 * i);
        end

        // Early trigger, buffer not yet full
        capture(32'h4, 1'b1, k);
        chk("s3.k_done", k, 4);
        chk("s3.count", cnt[0], 5);
        chk("s3.trig_idx", tidx[0], 1);
        rd_addr = 3'd1; cycle();
        chk("s3.rd1", rpc[0], 32'h4);

        // Timeout with trigger disabled
        capture(32'h0, 1'b0, k);
        chk("s4.k_done", k, TIMEOUT - 1);
        chk("s4.done", done[0], 1);
        chk("s4.timeout", tout[0], 1);
        chk("s4.trig_hit", hit[0], 0);
        chk("s4.count", cnt[0], 8);

        // Re-arm from DONE, gapped samples, ignored arm pulse in PRE
        arm = 1'b1; cycle(); arm = 1'b0;
        chk("s5.count0", cnt[0], 0);
        chk("s5.done0", done[0], 0);
        chk("s5.state0", st[0], 1);
        trig_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vld = (i % 2 == 0); arm = (i == 3);
            pc = DATA_W'(32'h200 + 4 * i); data = $urandom;
            cycle();
        end
        arm = 1'b0; vld = 1'b0;
        chk("s5.count", cnt[0], 5);
        chk("s5.state", st[0], 1);
        wait_done();

        // POST_CNT=0 instance with trigger on the first sample
        trig_pc = 32'h0; trig_en = 1'b1;
        arm = 1'b1; cycle(); arm = 1'b0;
        vld = 1'b1; pc = 32'h0; data = $urandom; cycle();
        chk("s6.done", done[1], 1);
        chk("s6.count", cnt[1], 1);
        chk("s6.trig_idx", tidx[1], 0);
        wait_done();

        // Timeout cuts POST short; then trigger coincident with timeout
        capture(32'hC0, 1'b1, k);
        chk("s7.k_done", k, TIMEOUT - 1);
        chk("s7.timeout", tout[0], 1);
        chk("s7.trig_hit", hit[0], 1);
        chk("s7.trig_idx", tidx[0], 6);
        chk("s7.u1_trig_idx", tidx[1], 7);
        capture(32'hC4, 1'b1, k);
        chk("s8.timeout", tout[0], 1);
        chk("s8.trig_hit", hit[0], 1);
        chk("s8.trig_idx", tidx[0], 7);
        chk("s8.u1_timeout", tout[1], 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) trig_pc = DATA_W'(4 * $urandom_range(0, 15));
            arm     = ($urandom_range(0, 19) == 0);
            vld     = ($urandom_range(0, 3) != 0);
            trig_en = ($urandom_range(0, 7) != 0);
            pc      = DATA_W'(4 * $urandom_range(0, 15));
            data    = $urandom;
            rd_addr = AW'($urandom_range(0, 7));
            cycle();
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
